multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// Multicycle CPU control sequencer: fetch/decode/exec/mem/writeback FSM with memory handshake.
// Optional feature: define SEQ_TRAP_EN to trap on undefined opcodes (sticky TRAP, HALT state).
module multicycle_seq (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RUN,
   input  logic [3:0] OP,
   input  logic       ZERO,
   input  logic       MEM_READY,
   output logic       MEMREQ,
   output logic       MEMWE,
   output logic       IORD,
   output logic       IRWRITE,
   output logic       PCWRITE,
   output logic [1:0] PCSRC,
   output logic [2:0] ALUC,
   output logic       ALUSRCB,
   output logic       REGWRITE,
   output logic       MEMTOREG,
   output logic       REGDES,
   output logic       WRFLAG,
   output logic       RETIRED,
   output logic       TRAP,
   output logic [2:0] STATE
);

   // state  | meaning
   // IDLE   | not fetching; waits for RUN
   // FETCH  | instruction read from PC; IR/PC load on MEM_READY
   // DECODE | JMP retires here; undefined opcode handled here
   // EXEC   | ALU cycle; branches retire here
   // MEM    | data access at ALU address; SW retires on MEM_READY
   // WB     | register-file write and retire
   // HALT   | trapped on undefined opcode; only RST leaves
   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b011,
      S_MEM    = 3'b100,
      S_WB     = 3'b101,
      S_HALT   = 3'b110
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_ANDI = 4'd6;
   localparam logic [3:0] OP_ORI  = 4'd7;
   localparam logic [3:0] OP_LW   = 4'd8;
   localparam logic [3:0] OP_SW   = 4'd9;
   localparam logic [3:0] OP_BEQ  = 4'd10;
   localparam logic [3:0] OP_BNE  = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_ADDC = 4'd13;
   localparam logic [3:0] OP_SUBC = 4'd14;
   localparam logic [3:0] OP_UND  = 4'd15;

   localparam logic [2:0] AC_AN  = 3'd0;
   localparam logic [2:0] AC_OR  = 3'd1;
   localparam logic [2:0] AC_ADX = 3'd2;
   localparam logic [2:0] AC_SBX = 3'd3;
   localparam logic [2:0] AC_LS  = 3'd4;
   localparam logic [2:0] AC_AD  = 3'd5;
   localparam logic [2:0] AC_SB  = 3'd6;

   state_t state_q, state_d;
   state_t next_st;
   logic   op_rr, op_flag, op_legal;

   assign op_rr    = OP inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDC, OP_SUBC};
   assign op_flag  = OP inside {OP_ADD, OP_SUB, OP_ADDI, OP_ADDC, OP_SUBC};
   assign op_legal = (OP != OP_UND);
   assign next_st  = RUN ? S_FETCH : S_IDLE;

   always_comb begin
      unique case (OP)
         OP_SLT:                  ALUC = AC_LS;
         OP_OR, OP_ORI:           ALUC = AC_OR;
         OP_SUB, OP_BEQ, OP_BNE:  ALUC = AC_SBX;
         OP_AND, OP_ANDI:         ALUC = AC_AN;
         OP_ADDC:                 ALUC = AC_AD;
         OP_SUBC:                 ALUC = AC_SB;
         default:                 ALUC = AC_ADX;
      endcase
      ALUSRCB = OP inside {OP_ORI, OP_ADDI, OP_ANDI, OP_LW, OP_SW};
   end

   // Strobes are Mealy on MEM_READY/ZERO so a handshake completes in the same cycle.
   always_comb begin
      state_d  = state_q;
      MEMREQ   = 1'b0;
      MEMWE    = 1'b0;
      IORD     = 1'b0;
      IRWRITE  = 1'b0;
      PCWRITE  = 1'b0;
      PCSRC    = 2'b00;
      REGWRITE = 1'b0;
      MEMTOREG = 1'b0;
      REGDES   = 1'b0;
      WRFLAG   = 1'b0;
      RETIRED  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (RUN) state_d = S_FETCH;
         end
         S_FETCH: begin
            MEMREQ = 1'b1;
            if (MEM_READY) begin
               IRWRITE = 1'b1;
               PCWRITE = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (OP == OP_JMP) begin
               PCWRITE = 1'b1;
               PCSRC   = 2'b10;
               RETIRED = 1'b1;
               state_d = next_st;
            end else if (op_legal) begin
               state_d = S_EXEC;
            end else begin
`ifdef SEQ_TRAP_EN
               state_d = S_HALT;
`else
               RETIRED = 1'b1;
               state_d = next_st;
`endif
            end
         end
         S_EXEC: begin
            if (OP == OP_BEQ || OP == OP_BNE) begin
               PCWRITE = (OP == OP_BEQ) ? ZERO : ~ZERO;
               PCSRC   = 2'b01;
               RETIRED = 1'b1;
               state_d = next_st;
            end else if (OP == OP_LW || OP == OP_SW) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            MEMREQ = 1'b1;
            IORD   = 1'b1;
            MEMWE  = (OP == OP_SW);
            if (MEM_READY) begin
               if (OP == OP_SW) begin
                  RETIRED = 1'b1;
                  state_d = next_st;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            REGWRITE = 1'b1;
            MEMTOREG = (OP == OP_LW);
            REGDES   = op_rr;
            WRFLAG   = op_flag;
            RETIRED  = 1'b1;
            state_d  = next_st;
         end
`ifdef SEQ_TRAP_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

`ifdef SEQ_TRAP_EN
   logic trap_q, trap_d;

   assign trap_d = trap_q | (state_q == S_DECODE && !op_legal);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) trap_q <= 1'b0;
      else     trap_q <= trap_d;
   end

   assign TRAP = trap_q;
`else
   assign TRAP = 1'b0;
`endif

   assign STATE = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Randomized self-checking bench for multicycle_seq: per-instruction expected cycle traces
// are derived from opcode class, wait counts and ZERO, then compared every cycle.
module tb_multicycle_seq;

   logic       CLK = 1'b0;
   logic       RST, RUN, ZERO, MEM_READY;
   logic [3:0] OP;
   logic       MEMREQ, MEMWE, IORD, IRWRITE, PCWRITE, ALUSRCB;
   logic       REGWRITE, MEMTOREG, REGDES, WRFLAG, RETIRED, TRAP;
   logic [1:0] PCSRC;
   logic [2:0] ALUC, STATE;

   multicycle_seq dut (
      .CLK(CLK), .RST(RST), .RUN(RUN), .OP(OP), .ZERO(ZERO), .MEM_READY(MEM_READY),
      .MEMREQ(MEMREQ), .MEMWE(MEMWE), .IORD(IORD), .IRWRITE(IRWRITE), .PCWRITE(PCWRITE),
      .PCSRC(PCSRC), .ALUC(ALUC), .ALUSRCB(ALUSRCB), .REGWRITE(REGWRITE),
      .MEMTOREG(MEMTOREG), .REGDES(REGDES), .WRFLAG(WRFLAG), .RETIRED(RETIRED),
      .TRAP(TRAP), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
   localparam logic [3:0] OP_SLT = 4'd4,  OP_ADDI = 4'd5, OP_ANDI = 4'd6, OP_ORI = 4'd7;
   localparam logic [3:0] OP_LW = 4'd8,   OP_SW = 4'd9,   OP_BEQ = 4'd10, OP_BNE = 4'd11;
   localparam logic [3:0] OP_JMP = 4'd12, OP_ADDC = 4'd13, OP_SUBC = 4'd14, OP_UND = 4'd15;

   typedef struct packed {
      logic [2:0] st;
      logic       memreq, iord, memwe, irwrite, pcwrite;
      logic [1:0] pcsrc;
      logic       regwrite, memtoreg, regdes, wrflag, retired, trap;
   } exp_t;

   typedef struct packed {
      logic rdy;
      exp_t e;
   } cyc_t;

   cyc_t tr[$];
   exp_t exp_c;
   bit   exp_valid = 1'b0;
   bit   in_idle;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t act_vec();
      exp_t a;
      a = {STATE, MEMREQ, IORD, MEMWE, IRWRITE, PCWRITE, PCSRC,
           REGWRITE, MEMTOREG, REGDES, WRFLAG, RETIRED, TRAP};
      return a;
   endfunction

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic logic [3:0] alu_model(input logic [3:0] op);
      case (op)
         OP_SLT:                 return {3'd4, 1'b0};
         OP_OR:                  return {3'd1, 1'b0};
         OP_ORI:                 return {3'd1, 1'b1};
         OP_ADD:                 return {3'd2, 1'b0};
         OP_ADDI, OP_LW, OP_SW:  return {3'd2, 1'b1};
         OP_SUB, OP_BEQ, OP_BNE: return {3'd3, 1'b0};
         OP_AND:                 return {3'd0, 1'b0};
         OP_ANDI:                return {3'd0, 1'b1};
         OP_ADDC:                return {3'd5, 1'b0};
         OP_SUBC:                return {3'd6, 1'b0};
         default:                return {3'd2, 1'b0};
      endcase
   endfunction

   function automatic void push(input logic rdy, input exp_t e);
      cyc_t c;
      c.rdy = rdy;
      c.e   = e;
      tr.push_back(c);
   endfunction

   // Expected per-cycle trace of one instruction, from FETCH through retire.
   function automatic void build(input logic [3:0] op, input logic z, input int fw, input int mw);
      exp_t e;
      tr.delete();
      for (int i = 0; i < fw; i++) begin
         e = blank(3'd1); e.memreq = 1'b1;
         push(1'b0, e);
      end
      e = blank(3'd1); e.memreq = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      push(1'b1, e);
      e = blank(3'd2);
      if (op == OP_JMP) begin
         e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.retired = 1'b1;
         push(1'($urandom), e);
         return;
      end
      if (op == OP_UND) begin
`ifndef SEQ_TRAP_EN
         e.retired = 1'b1;
`endif
         push(1'($urandom), e);
         return;
      end
      push(1'($urandom), e);
      e = blank(3'd3);
      if (op == OP_BEQ || op == OP_BNE) begin
         e.pcwrite = (op == OP_BEQ) ? z : !z;
         e.pcsrc = 2'b01; e.retired = 1'b1;
         push(1'($urandom), e);
         return;
      end
      push(1'($urandom), e);
      if (op == OP_LW || op == OP_SW) begin
         for (int i = 0; i <= mw; i++) begin
            e = blank(3'd4); e.memreq = 1'b1; e.iord = 1'b1; e.memwe = (op == OP_SW);
            if (i == mw && op == OP_SW) e.retired = 1'b1;
            push(i == mw, e);
         end
         if (op == OP_SW) return;
      end
      e = blank(3'd5);
      e.regwrite = 1'b1;
      e.memtoreg = (op == OP_LW);
      e.regdes   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDC, OP_SUBC};
      e.wrflag   = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_ADDC, OP_SUBC};
      e.retired  = 1'b1;
      push(1'($urandom), e);
   endfunction

   always @(negedge CLK) begin
      #2;
      if (exp_valid) begin
         chk("outs", {16'b0, act_vec()}, {16'b0, exp_c});
         chk("alu", {28'b0, ALUC, ALUSRCB}, {28'b0, alu_model(OP)});
      end
   end

   task automatic step(input logic run, input logic rdy, input logic z, input logic [3:0] op,
                       input exp_t e);
      @(negedge CLK);
      RUN = run; MEM_READY = rdy; ZERO = z; OP = op;
      exp_c = e; exp_valid = 1'b1;
   endtask

   // Reset must clear the outputs asynchronously, before any clock edge.
   task automatic do_reset(input string name);
      @(negedge CLK);
      exp_valid = 1'b0;
      RUN = 1'b1;
      RST = 1'b1;
      #1;
      chk(name, {16'b0, act_vec()}, {16'b0, blank(3'd0)});
      @(negedge CLK);
      RST = 1'b0;
      RUN = 1'b0;
      in_idle = 1'b1;
   endtask

   task automatic idle_phase();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), blank(3'd0));
      step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), blank(3'd0));
   endtask

   task automatic exec_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                             input logic run_after, input int abort_at);
      logic [2:0] st;
      if (in_idle) idle_phase();
      build(op, z, fw, mw);
      for (int i = 0; i < tr.size(); i++) begin
         if (i == abort_at) begin
            do_reset("rst_mid");
            return;
         end
         st = tr[i].e.st;
         step((i == tr.size() - 1) ? run_after : 1'($urandom),
              tr[i].rdy,
              (st == 3'd3) ? z : 1'($urandom),
              (st == 3'd1) ? 4'($urandom) : op,
              tr[i].e);
      end
`ifdef SEQ_TRAP_EN
      if (op == OP_UND) begin
         exp_t h;
         h = blank(3'd6); h.trap = 1'b1;
         for (int i = 0; i < 4; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), h);
         do_reset("rst_halt");
         return;
      end
`endif
      in_idle = !run_after;
   endtask

   initial begin
      RST = 1'b1; RUN = 1'b0; ZERO = 1'b0; MEM_READY = 1'b0; OP = 4'd0;
      repeat (2) @(negedge CLK);
      chk("reset_state", {16'b0, act_vec()}, {16'b0, blank(3'd0)});
      RST = 1'b0;
      in_idle = 1'b1;

      // Hand-computed anchors for the reference model.
      build(OP_ADD, 1'b0, 0, 0);
      chk("pin_add_len", tr.size(), 4);
      chk("pin_add_states", {tr[0].e.st, tr[1].e.st, tr[2].e.st, tr[3].e.st}, 12'h29D);
      chk("pin_add_wb", {tr[3].e.regwrite, tr[3].e.regdes, tr[3].e.wrflag, tr[3].e.retired}, 4'hF);
      build(OP_LW, 1'b0, 0, 3);
      chk("pin_lw_len", tr.size(), 8);
      chk("pin_lw_wb", {tr[7].e.memtoreg, tr[7].e.retired, tr[6].e.memreq, tr[6].e.memwe}, 4'b1110);
      build(OP_BEQ, 1'b1, 0, 0);
      chk("pin_beq1", {tr.size() == 3, tr[2].e.pcwrite, tr[2].e.pcsrc}, 4'b1101);
      build(OP_BEQ, 1'b0, 0, 0);
      chk("pin_beq0", {tr.size() == 3, tr[2].e.pcwrite, tr[2].e.retired}, 3'b101);
      build(OP_JMP, 1'b0, 0, 0);
      chk("pin_jmp_len", tr.size(), 2);
      build(OP_SW, 1'b0, 1, 0);
      chk("pin_sw_len", tr.size(), 5);

      exec_instr(OP_ADD, 1'b0, 0, 0, 1'b1, -1);
      exec_instr(OP_LW,  1'b0, 0, 3, 1'b1, -1);
      exec_instr(OP_BEQ, 1'b0, 0, 0, 1'b1, -1);
      exec_instr(OP_BEQ, 1'b1, 0, 0, 1'b1, -1);
      exec_instr(OP_SW,  1'b0, 0, 1, 1'b0, -1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), blank(3'd0));
      exec_instr(OP_JMP, 1'b0, 1, 0, 1'b1, -1);
      exec_instr(OP_UND, 1'b0, 0, 0, 1'b1, -1);
      exec_instr(OP_ADD, 1'b0, 3, 0, 1'b1, 1);
      exec_instr(OP_LW,  1'b0, 0, 3, 1'b1, 4);

      for (int n = 0; n < 250; n++) begin
         exec_instr(4'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    ($urandom % 4) != 0, (($urandom % 16) == 0) ? $urandom_range(0, 4) : -1);
      end

      @(negedge CLK);
      exp_valid = 1'b0;
      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
